// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the approximate-multiplier error accumulator.
//   state_e      : run-control FSM states (IDLE, RUN, DRAIN, DONE)
//   prod_t       : product type for the default 16-bit operand width
//   sat_overflow : saturation helper; reports whether a widened sum no longer
//                  fits in an accumulator of acc_w bits
// -----------------------------------------------------------------------------
package mult_pkg;

    localparam int unsigned DEF_WIDTH = 16;

    // Widest sum the saturation helper can inspect. Accumulators up to
    // SAT_W-2 bits wide are supported.
    localparam int unsigned SAT_W = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef logic [2*DEF_WIDTH-1:0] prod_t;

    // True when any bit at or above position acc_w is set, i.e. the sum
    // exceeded 2^acc_w - 1 and the accumulator must pin at all-ones.
    function automatic logic sat_overflow(input logic [SAT_W-1:0] sum,
                                          input int unsigned      acc_w);
        return (sum >> acc_w) != '0;
    endfunction

endpackage

// File: rtl/mult_err_calc.sv
// -----------------------------------------------------------------------------
// mult_err_calc
// Two-stage error datapath: stage 1 registers the exact product and the
// approximate product, stage 2 registers |exact - approx|. A valid bit travels
// alongside each stage so downstream logic only sees accepted samples.
// Ports:
//   clk_i     : rising-edge clock
//   rst_ni    : synchronous active-low reset (clears valid pipeline and data)
//   valid_i   : sample accepted this cycle
//   in1_i     : multiplicand, unsigned
//   in2_i     : multiplier, unsigned
//   approx_i  : approximate product for in1_i * in2_i
//   valid_o   : err_o holds a valid absolute error
//   err_o     : absolute error, 2*WIDTH bits
// -----------------------------------------------------------------------------
module mult_err_calc #(
    parameter  int unsigned WIDTH = 16,
    localparam int unsigned PW    = 2 * WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] in1_i,
    input  logic [WIDTH-1:0] in2_i,
    input  logic [PW-1:0]    approx_i,
    output logic             valid_o,
    output logic [PW-1:0]    err_o
);

    logic          v1_q;
    logic [PW-1:0] exact_d;
    logic [PW-1:0] exact_q;
    logic [PW-1:0] approx_q;

    logic          v2_q;
    logic [PW-1:0] err_d;
    logic [PW-1:0] err_q;

    // Operands are widened first so the product keeps all 2*WIDTH bits.
    assign exact_d = PW'(in1_i) * PW'(in2_i);

    // Unsigned magnitude of the difference, no sign bit kept.
    assign err_d = (exact_q >= approx_q) ? (exact_q - approx_q)
                                         : (approx_q - exact_q);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            v1_q     <= 1'b0;
            exact_q  <= '0;
            approx_q <= '0;
            v2_q     <= 1'b0;
            err_q    <= '0;
        end else begin
            v1_q     <= valid_i;
            exact_q  <= exact_d;
            approx_q <= approx_i;
            v2_q     <= v1_q;
            err_q    <= err_d;
        end
    end

    assign valid_o = v2_q;
    assign err_o   = err_q;

endmodule

// File: rtl/mult_err_accum.sv
// -----------------------------------------------------------------------------
// mult_err_accum
// Error-statistics accumulator placed behind the approximate multiplier. Over
// a run of NSAMP accepted samples it accumulates the saturating sum, the
// maximum and the count of nonzero absolute errors |in1*in2 - approx_prod|.
//
// Handshake: a sample transfers on a rising edge where in_valid && in_ready;
// in_ready is high only in RUN, and samples offered at any other time are
// dropped without effect.
//
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   start        : one-cycle pulse; in IDLE/DONE starts a run and clears stats
//   in_valid     : sample offered
//   in_ready     : sample accepted this cycle when in_valid is also high
//   in1, in2     : unsigned operands
//   approx_prod  : approximate product for in1/in2
//   busy         : high in RUN and DRAIN
//   done         : high in DONE; statistics are final
//   err_sum      : saturating sum of absolute errors
//   err_max      : largest absolute error of the run
//   err_cnt      : samples with nonzero error
//   samp_cnt     : samples accepted this run
//   state_dbg    : current FSM state, for observation only
//
// Timing: accept at edge t, stage 1 at t, stage 2 at t+1, statistics at t+2.
// The last accept moves to DRAIN at t and DONE at t+2, so done rises exactly
// when the final sample lands in the statistics. ACC_W must be >= 2*WIDTH and
// <= 126.
// -----------------------------------------------------------------------------
module mult_err_accum
    import mult_pkg::*;
#(
    parameter  int unsigned WIDTH = 16,
    parameter  int unsigned NSAMP = 1024,
    parameter  int unsigned ACC_W = 48,
    localparam int unsigned PW    = 2 * WIDTH,
    localparam int unsigned CW    = $clog2(NSAMP + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [PW-1:0]    approx_prod,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] err_sum,
    output logic [PW-1:0]    err_max,
    output logic [CW-1:0]    err_cnt,
    output logic [CW-1:0]    samp_cnt,
    output state_e           state_dbg
);

    // ------------------------------------------------------------------
    // Control signals
    // ------------------------------------------------------------------
    state_e state_q, state_d;
    logic   drain_q, drain_d;   // counts the two DRAIN cycles
    logic   accept;
    logic   clear_stats;
    logic   last_samp;

    logic             err_vld;
    logic [PW-1:0]    err_w;

    logic [ACC_W-1:0] err_sum_q, err_sum_d;
    logic [PW-1:0]    err_max_q, err_max_d;
    logic [CW-1:0]    err_cnt_q, err_cnt_d;
    logic [CW-1:0]    samp_cnt_q, samp_cnt_d;
    logic [ACC_W:0]   sum_wide;

    assign last_samp = (samp_cnt_q == CW'(NSAMP - 1));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. start is only honoured in IDLE and DONE.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        drain_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                if (accept && last_samp) state_d = DRAIN;
            end
            DRAIN: begin
                // Two cycles: drain_q is 0 on entry, 1 on the second cycle.
                drain_d = !drain_q;
                if (drain_q) state_d = DONE;
            end
            DONE: begin
                if (start) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        clear_stats = 1'b0;
        unique case (state_q)
            IDLE:  clear_stats = start;
            RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            DRAIN: busy = 1'b1;
            DONE: begin
                done        = 1'b1;
                clear_stats = start;
            end
            default: ;
        endcase
    end

    assign accept    = in_valid && in_ready;
    assign state_dbg = state_q;

    // ------------------------------------------------------------------
    // Error datapath (stages 1 and 2)
    // ------------------------------------------------------------------
    mult_err_calc #(
        .WIDTH (WIDTH)
    ) u_calc (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .valid_i  (accept),
        .in1_i    (in1),
        .in2_i    (in2),
        .approx_i (approx_prod),
        .valid_o  (err_vld),
        .err_o    (err_w)
    );

    // ------------------------------------------------------------------
    // Counters and accumulators
    // ------------------------------------------------------------------
    // One extra bit catches the carry out of the accumulator.
    assign sum_wide = {1'b0, err_sum_q} + {{(ACC_W + 1 - PW){1'b0}}, err_w};

    always_comb begin
        err_sum_d  = err_sum_q;
        err_max_d  = err_max_q;
        err_cnt_d  = err_cnt_q;
        samp_cnt_d = samp_cnt_q;
        if (clear_stats) begin
            // Pipeline is empty in IDLE/DONE, so nothing is lost here.
            err_sum_d  = '0;
            err_max_d  = '0;
            err_cnt_d  = '0;
            samp_cnt_d = '0;
        end else begin
            if (accept) begin
                samp_cnt_d = samp_cnt_q + CW'(1);
            end
            if (err_vld) begin
                if (sat_overflow({{(SAT_W - ACC_W - 1){1'b0}}, sum_wide}, ACC_W)) begin
                    err_sum_d = '1;
                end else begin
                    err_sum_d = sum_wide[ACC_W-1:0];
                end
                if (err_w > err_max_q) begin
                    err_max_d = err_w;
                end
                if (err_w != '0) begin
                    err_cnt_d = err_cnt_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_sum_q  <= '0;
            err_max_q  <= '0;
            err_cnt_q  <= '0;
            samp_cnt_q <= '0;
        end else begin
            err_sum_q  <= err_sum_d;
            err_max_q  <= err_max_d;
            err_cnt_q  <= err_cnt_d;
            samp_cnt_q <= samp_cnt_d;
        end
    end

    assign err_sum  = err_sum_q;
    assign err_max  = err_max_q;
    assign err_cnt  = err_cnt_q;
    assign samp_cnt = samp_cnt_q;

endmodule

// File: tb/tb_mult_err_accum.sv
// -----------------------------------------------------------------------------
// tb_mult_err_accum
// Directed bench for mult_err_accum with NSAMP=4. Two instances share all
// inputs: u_acc48 (ACC_W=48) is the main reference target, u_acc32 (ACC_W=32)
// shows accumulator saturation. Inputs change on the falling edge; outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mult_err_accum;
    import mult_pkg::*;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned NSAMP = 4;
    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CW    = $clog2(NSAMP + 1);

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic             start       = 1'b0;
    logic             in_valid    = 1'b0;
    logic [WIDTH-1:0] in1         = '0;
    logic [WIDTH-1:0] in2         = '0;
    logic [PW-1:0]    approx_prod = '0;

    logic          rdy_a, busy_a, done_a;
    logic [47:0]   sum_a;
    prod_t         max_a;
    logic [CW-1:0] ecnt_a, scnt_a;
    state_e        st_a;

    logic          rdy_b, busy_b, done_b;
    logic [31:0]   sum_b;
    prod_t         max_b;
    logic [CW-1:0] ecnt_b, scnt_b;
    state_e        st_b;

    mult_err_accum #(.WIDTH(WIDTH), .NSAMP(NSAMP), .ACC_W(48)) u_acc48 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(rdy_a), .in1(in1), .in2(in2), .approx_prod(approx_prod),
        .busy(busy_a), .done(done_a), .err_sum(sum_a), .err_max(max_a),
        .err_cnt(ecnt_a), .samp_cnt(scnt_a), .state_dbg(st_a)
    );

    mult_err_accum #(.WIDTH(WIDTH), .NSAMP(NSAMP), .ACC_W(32)) u_acc32 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(rdy_b), .in1(in1), .in2(in2), .approx_prod(approx_prod),
        .busy(busy_b), .done(done_b), .err_sum(sum_b), .err_max(max_b),
        .err_cnt(ecnt_b), .samp_cnt(scnt_b), .state_dbg(st_b)
    );

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [47:0] exp_q[$];   // expected err_sum of each run, in run order

    task automatic check_val(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One cycle of stimulus: set inputs, let one rising edge pass, return at
    // the following falling edge with valid/start released.
    task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [PW-1:0] p, input logic v, input logic st);
        in1         = a;
        in2         = b;
        approx_prod = p;
        in_valid    = v;
        start       = st;
        @(negedge clk);
        in_valid    = 1'b0;
        start       = 1'b0;
    endtask

    task automatic pulse_start();
        drive('0, '0, '0, 1'b0, 1'b1);
    endtask

    task automatic idle_cycle();
        drive('0, '0, '0, 1'b0, 1'b0);
    endtask

    // Called at the falling edge after the last accept; counts cycles to done.
    task automatic wait_done(input string tag, input int exp_lat);
        int cycles;
        cycles = 0;
        while (!done_a && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        check_val({tag, "_done_lat"}, 64'(cycles), 64'(exp_lat));
    endtask

    task automatic check_stats(input string tag, input logic [PW-1:0] e_max,
                               input logic [CW-1:0] e_cnt, input logic [CW-1:0] e_samp);
        logic [47:0] e_sum;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_sum: expected queue empty", tag);
        end else begin
            e_sum = exp_q.pop_front();
            check_val({tag, "_sum"}, 64'(sum_a), 64'(e_sum));
        end
        check_val({tag, "_max"},  64'(max_a),  64'(e_max));
        check_val({tag, "_ecnt"}, 64'(ecnt_a), 64'(e_cnt));
        check_val({tag, "_samp"}, 64'(scnt_a), 64'(e_samp));
        check_val({tag, "_done"}, 64'(done_a), 64'd1);
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_rdy"},   64'(rdy_a),  64'd0);
        check_val({tag, "_busy"},  64'(busy_a), 64'd0);
        check_val({tag, "_done"},  64'(done_a), 64'd0);
        check_val({tag, "_sum"},   64'(sum_a),  64'd0);
        check_val({tag, "_max"},   64'(max_a),  64'd0);
        check_val({tag, "_ecnt"},  64'(ecnt_a), 64'd0);
        check_val({tag, "_samp"},  64'(scnt_a), 64'd0);
        check_val({tag, "_state"}, 64'(st_a),   64'(IDLE));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(negedge clk);
        check_reset_state("por");
        rst_n = 1'b1;

        // Exact match: four samples of 2*4 = 8.
        exp_q.push_back(48'd0);
        pulse_start();
        check_val("t1_busy", 64'(busy_a), 64'd1);
        check_val("t1_rdy",  64'(rdy_a),  64'd1);
        repeat (4) drive(16'd2, 16'd4, 32'd8, 1'b1, 1'b0);
        check_val("t1_drain_rdy",   64'(rdy_a), 64'd0);
        check_val("t1_drain_state", 64'(st_a),  64'(DRAIN));
        wait_done("t1", 2);
        check_stats("t1", 32'd0, 3'd0, 3'd4);

        // Mixed errors: -3, +5, 0, -1.
        exp_q.push_back(48'd9);
        pulse_start();
        drive(16'd3,    16'd7,    32'd18,         1'b1, 1'b0);
        drive(16'd1000, 16'd1000, 32'd1000005,    1'b1, 1'b0);
        check_val("t2_lead_samp", 64'(scnt_a), 64'd2);
        check_val("t2_lead_ecnt", 64'(ecnt_a), 64'd0);
        drive(16'hFFFF, 16'hFFFF, 32'hFFFE0001,   1'b1, 1'b0);
        drive(16'd12,   16'd12,   32'd143,        1'b1, 1'b0);
        wait_done("t2", 2);
        check_stats("t2", 32'd5, 3'd3, 3'd4);

        // Throttling with samples offered in DONE and DRAIN.
        drive(16'hFFFF, 16'hFFFF, 32'd0, 1'b1, 1'b0);
        drive(16'hFFFF, 16'hFFFF, 32'd0, 1'b1, 1'b0);
        check_val("t3_done_drop_sum",  64'(sum_a),  64'd9);
        check_val("t3_done_drop_samp", 64'(scnt_a), 64'd4);
        exp_q.push_back(48'd10);
        pulse_start();
        drive(16'd5,    16'd5,    32'd20, 1'b1, 1'b0);
        drive(16'hFFFF, 16'hFFFF, 32'd0,  1'b0, 1'b0);
        drive(16'd2,    16'd3,    32'd10, 1'b1, 1'b0);
        drive(16'hFFFF, 16'hFFFF, 32'd0,  1'b0, 1'b0);
        drive(16'd7,    16'd7,    32'd49, 1'b1, 1'b0);
        drive(16'hFFFF, 16'hFFFF, 32'd0,  1'b0, 1'b0);
        drive(16'd10,   16'd10,   32'd99, 1'b1, 1'b0);
        drive(16'hFFFF, 16'hFFFF, 32'd0,  1'b1, 1'b0);
        drive(16'hFFFF, 16'hFFFF, 32'd0,  1'b1, 1'b0);
        check_stats("t3", 32'd5, 3'd3, 3'd4);

        // Saturation: 0xFFFF*0xFFFF against approx 0.
        exp_q.push_back(48'h3_FFF8_0004);
        pulse_start();
        repeat (4) drive(16'hFFFF, 16'hFFFF, 32'd0, 1'b1, 1'b0);
        wait_done("t4", 2);
        check_stats("t4", 32'hFFFE0001, 3'd4, 3'd4);
        check_val("t4_a32_done", 64'(done_b), 64'd1);
        check_val("t4_a32_sum",  64'(sum_b),  64'hFFFF_FFFF);
        check_val("t4_a32_max",  64'(max_b),  64'hFFFE_0001);

        // Reset mid-run after two accepts.
        pulse_start();
        repeat (2) drive(16'd3, 16'd3, 32'd7, 1'b1, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_state("t5_rst");
        rst_n = 1'b1;
        repeat (3) idle_cycle();
        check_val("t5_idle_sum",   64'(sum_a), 64'd0);
        check_val("t5_idle_state", 64'(st_a),  64'(IDLE));
        exp_q.push_back(48'd8);
        pulse_start();
        repeat (4) drive(16'd3, 16'd3, 32'd7, 1'b1, 1'b0);
        wait_done("t5", 2);
        check_stats("t5", 32'd2, 3'd4, 3'd4);

        // Start in RUN is ignored; the third sample carries a start pulse.
        exp_q.push_back(48'd10);
        pulse_start();
        drive(16'd1, 16'd1, 32'd2, 1'b1, 1'b0);
        drive(16'd1, 16'd1, 32'd3, 1'b1, 1'b0);
        drive(16'd1, 16'd1, 32'd4, 1'b1, 1'b1);
        drive(16'd1, 16'd1, 32'd5, 1'b1, 1'b0);
        wait_done("t6", 2);
        check_stats("t6", 32'd4, 3'd4, 3'd4);

        // Start in DONE clears everything; next run is independent.
        pulse_start();
        check_val("t7_clr_sum",  64'(sum_a),  64'd0);
        check_val("t7_clr_max",  64'(max_a),  64'd0);
        check_val("t7_clr_ecnt", 64'(ecnt_a), 64'd0);
        check_val("t7_clr_samp", 64'(scnt_a), 64'd0);
        check_val("t7_clr_busy", 64'(busy_a), 64'd1);
        exp_q.push_back(48'd0);
        repeat (4) drive(16'd2, 16'd4, 32'd8, 1'b1, 1'b0);
        wait_done("t7", 2);
        check_stats("t7", 32'd0, 3'd0, 3'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got no summary, expected completion");
        $fatal(1, "timeout");
    end

endmodule
